// File: rtl/fact_inverse_if.sv
// fact_inverse_if: start/busy/done handshake bundle for the inverse-factorial finder.
// master = requester (drives start/value), slave = the fact_inverse engine.
interface fact_inverse_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             valid;
    logic [3:0]       n;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  valid,
        input  n
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output valid,
        output n
    );
endinterface

// File: rtl/fact_inverse.sv
// fact_inverse: sequential inverse factorial. It takes a WIDTH-bit value and builds
// the running product 1*2*...*k with one multiply per clock, stopping on an exact
// match, an overshoot, or when k reaches MAX_N. It reports valid/n with a one-cycle
// done pulse.
// Optional feature: define FACT_INV_FLOOR_EN so that a miss reports the largest j
// with j! < value in n. When it is undefined, a miss reports n = 0.
module fact_inverse #(
    parameter int WIDTH = 32,
    parameter int MAX_N = 12
) (
    input  logic           clk,
    input  logic           rst,
    fact_inverse_if.slave  bus
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SEARCH = 1'b1;

    localparam logic [3:0] K_MAX = 4'(MAX_N);

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] p_q,      p_d;
    logic [3:0]       k_q,      k_d;
    logic             done_q,   done_d;
    logic             valid_q,  valid_d;
    logic [3:0]       n_q,      n_d;

    logic [3:0]       k_inc;
    logic [WIDTH-1:0] p_next;

    // Next factor and next running product. The product is truncated to WIDTH
    // bits; it is only used when p < target and k < MAX_N, so it cannot overflow.
    assign k_inc  = k_q + 4'd1;
    assign p_next = p_q * WIDTH'(k_inc);

    // Next-state logic: accept in IDLE, then compare and step once per cycle in SEARCH.
    always_comb begin
        // NOTE: every signal gets a default here first, so no path can leave one
        // unassigned and infer a latch.
        state_d  = state_q;
        target_d = target_q;
        p_d      = p_q;
        k_d      = k_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        n_d      = n_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    target_d = bus.value;
                    p_d      = '0;
                    p_d[0]   = 1'b1;
                    k_d      = 4'd1;
                    valid_d  = 1'b0;
                    n_d      = 4'd0;
                    state_d  = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (p_q == target_q) begin
                    // Exact factorial: k is the answer.
                    n_d     = k_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (p_q > target_q) begin
                    // Overshoot: (k-1)! < target < k!, or target is 0 at k = 1.
                    valid_d = 1'b0;
`ifdef FACT_INV_FLOOR_EN
                    n_d     = k_q - 4'd1;
`else
                    n_d     = 4'd0;
`endif
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (k_q == K_MAX) begin
                    // Ran out of range: target exceeds MAX_N!.
                    valid_d = 1'b0;
`ifdef FACT_INV_FLOOR_EN
                    n_d     = K_MAX;
`else
                    n_d     = 4'd0;
`endif
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_inc;
                    p_d = p_next;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset. Reset aborts a search with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the edge.
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            p_q      <= WIDTH'(1);
            k_q      <= 4'd1;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            n_q      <= 4'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            p_q      <= p_d;
            k_q      <= k_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            n_q      <= n_d;
        end
    end

    assign bus.busy  = (state_q == S_SEARCH);
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.n     = n_q;

endmodule
